// File: rtl/diff_freq_serial_in.sv
// Serial word receiver with per-bit period selection (fast/slow), forwarding the captured word byte by byte to a UART transmitter.
// Optional build macro DIFF_FREQ_MAJORITY_VOTE_EN: 2-of-3 majority sampling around the bit centre.
module diff_freq_serial_in #(
    parameter int DATA_BIT    = 32,
    parameter int TICK_10K_HZ = 63,
    parameter int TICK_20K_HZ = 31
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic [DATA_BIT-1:0] i_freq_pattern,
    input  logic                i_serial_in,
    input  logic                i_tx_done_tick,
    output logic [7:0]          o_tx_data,
    output logic                o_tx_start,
    output logic [DATA_BIT-1:0] o_data,
    output logic                o_data_valid,
    output logic                o_busy,
    output logic                o_done_tick
);

    localparam int TICK_MAX = (TICK_10K_HZ > TICK_20K_HZ) ? TICK_10K_HZ : TICK_20K_HZ;
    localparam int CNT_W    = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
    localparam int IDX_W    = $clog2(DATA_BIT);
    localparam int BYTES    = DATA_BIT / 8;
    localparam int BIDX_W   = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SAMPLE = 3'd1;
    localparam logic [2:0] S_SEND   = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]          r_state;
    logic [CNT_W-1:0]    r_tick;
    logic [IDX_W-1:0]    r_bit_idx;
    logic [BIDX_W-1:0]   r_byte_idx;
    logic [DATA_BIT-1:0] r_pattern;
    logic [DATA_BIT-1:0] r_data;
    logic [DATA_BIT-1:0] r_out_data;
    logic [7:0]          r_tx_data;
    logic                r_tx_start;
    logic                r_data_valid;
    logic                r_done_tick;

    logic [CNT_W-1:0]    w_period;
    logic [CNT_W-1:0]    w_mid;
    logic                w_sample_en;
    logic                w_sample_bit;
    logic [DATA_BIT-1:0] w_data_next;

    assign w_period = r_pattern[r_bit_idx] ? CNT_W'(TICK_20K_HZ) : CNT_W'(TICK_10K_HZ);
    assign w_mid    = w_period >> 1;

`ifdef DIFF_FREQ_MAJORITY_VOTE_EN
    // Samples at mid-1 and mid are held here; the vote resolves at mid+1.
    logic [1:0] r_vote;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vote <= 2'b00;
        end else if (r_state == S_SAMPLE) begin
            if (r_tick == w_mid - CNT_W'(1)) r_vote[0] <= i_serial_in;
            if (r_tick == w_mid)             r_vote[1] <= i_serial_in;
        end
    end

    assign w_sample_en  = (r_tick == w_mid + CNT_W'(1));
    assign w_sample_bit = (r_vote[0] & r_vote[1]) | (r_vote[0] & i_serial_in) |
                          (r_vote[1] & i_serial_in);
`else
    assign w_sample_en  = (r_tick == w_mid);
    assign w_sample_bit = i_serial_in;
`endif

    always_comb begin
        w_data_next = r_data;
        if (w_sample_en) w_data_next[r_bit_idx] = w_sample_bit;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_tick       <= '0;
            r_bit_idx    <= '0;
            r_byte_idx   <= '0;
            r_pattern    <= '0;
            r_data       <= '0;
            r_out_data   <= '0;
            r_tx_data    <= '0;
            r_tx_start   <= 1'b0;
            r_data_valid <= 1'b0;
            r_done_tick  <= 1'b0;
        end else begin
            r_tx_start   <= 1'b0;
            r_data_valid <= 1'b0;
            r_done_tick  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start && !i_stop) begin
                        r_pattern <= i_freq_pattern;
                        r_bit_idx <= '0;
                        r_tick    <= '0;
                        r_state   <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    if (i_stop) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_data <= w_data_next;
                        if (r_tick == w_period) begin
                            r_tick <= '0;
                            if (r_bit_idx == IDX_W'(DATA_BIT - 1)) begin
                                // Load from the next-data view so a sample on the final tick is not lost.
                                r_out_data   <= w_data_next;
                                r_data_valid <= 1'b1;
                                r_byte_idx   <= '0;
                                r_bit_idx    <= '0;
                                r_state      <= S_SEND;
                            end else begin
                                r_bit_idx <= r_bit_idx + IDX_W'(1);
                            end
                        end else begin
                            r_tick <= r_tick + CNT_W'(1);
                        end
                    end
                end
                S_SEND: begin
                    if (i_stop) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_tx_data  <= r_out_data[{r_byte_idx, 3'b000} +: 8];
                        r_tx_start <= 1'b1;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_stop) begin
                        r_state <= S_IDLE;
                    end else if (i_tx_done_tick) begin
                        if (r_byte_idx < BIDX_W'(BYTES - 1)) begin
                            r_byte_idx <= r_byte_idx + BIDX_W'(1);
                            r_state    <= S_SEND;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (!i_stop) r_done_tick <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_tx_data    = r_tx_data;
    assign o_tx_start   = r_tx_start;
    assign o_data       = r_out_data;
    assign o_data_valid = r_data_valid;
    assign o_done_tick  = r_done_tick;
    assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_diff_freq_serial_in.sv
// Directed bench for diff_freq_serial_in: capture timing, byte hand-off, abort, reset and glitch behaviour.
module tb_diff_freq_serial_in;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_stop = 1'b0;
    logic [31:0] i_freq_pattern = '0;
    logic        i_serial_in = 1'b0;
    logic        i_tx_done_tick = 1'b0;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic [31:0] o_data;
    logic        o_data_valid;
    logic        o_busy;
    logic        o_done_tick;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int n_valid = 0;
    int n_start = 0;
    int n_done = 0;

    diff_freq_serial_in dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_start        (i_start),
        .i_stop         (i_stop),
        .i_freq_pattern (i_freq_pattern),
        .i_serial_in    (i_serial_in),
        .i_tx_done_tick (i_tx_done_tick),
        .o_tx_data      (o_tx_data),
        .o_tx_start     (o_tx_start),
        .o_data         (o_data),
        .o_data_valid   (o_data_valid),
        .o_busy         (o_busy),
        .o_done_tick    (o_done_tick)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (o_data_valid) n_valid++;
        if (o_tx_start)   n_start++;
        if (o_done_tick)  n_done++;
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Starts a capture and drives the line; stop_at > 0 aborts in that capture cycle.
    task automatic capture(input logic [31:0] pat, input logic [31:0] dat, input bit glitch,
                           input bit noise, input int stop_at, input logic [31:0] exp_word,
                           input int exp_lat);
        int t0;
        int n;
        int per;
        logic v;
        t0 = cyc;
        i_freq_pattern = pat;
        i_start = 1'b1;
        i_serial_in = dat[0];
        step();
        i_start = 1'b0;
        n = 1;
        for (int k = 0; k < 32; k++) begin
            per = pat[k] ? 32 : 64;
            for (int t = 0; t < per; t++) begin
                if (stop_at > 0 && n == stop_at) begin
                    i_stop = 1'b1;
                    step();
                    i_stop = 1'b0;
                    i_serial_in = 1'b0;
                    check("stop_busy", {31'd0, o_busy}, 32'd0);
                    return;
                end
                v = dat[k];
                if (glitch && t == (per - 1) / 2) v = ~v;
                i_serial_in = v;
                i_tx_done_tick = noise && k == 2 && t == 3;
                i_start = noise && k == 2 && t == 3;
                if (k == 31 && t == per - 1) check("valid_early", {31'd0, o_data_valid}, 32'd0);
                step();
                n++;
            end
        end
        i_serial_in = 1'b0;
        i_tx_done_tick = 1'b0;
        i_start = 1'b0;
        check("valid_pulse", {31'd0, o_data_valid}, 32'd1);
        check("capture_word", o_data, exp_word);
        check("valid_latency", cyc - t0, exp_lat);
        check("busy_send", {31'd0, o_busy}, 32'd1);
    endtask

    // Acknowledges each byte after a short delay and checks the final done pulse.
    task automatic serve(input logic [31:0] w);
        logic [31:0] wv;
        wv = w;
        for (int b = 0; b < 4; b++) begin
            step();
            check("tx_start", {31'd0, o_tx_start}, 32'd1);
            check("tx_byte", {24'd0, o_tx_data}, {24'd0, wv[8*b +: 8]});
            repeat (3) step();
            check("tx_hold", {24'd0, o_tx_data}, {24'd0, wv[8*b +: 8]});
            check("tx_start_off", {31'd0, o_tx_start}, 32'd0);
            i_tx_done_tick = 1'b1;
            step();
            i_tx_done_tick = 1'b0;
        end
        step();
        check("done_tick", {31'd0, o_done_tick}, 32'd1);
        check("idle_after_done", {31'd0, o_busy}, 32'd0);
        step();
        check("done_tick_off", {31'd0, o_done_tick}, 32'd0);
    endtask

    initial begin
        int s_valid;
        int s_start;
        int s_done;
        logic [31:0] glitch_exp;

        // Reset state
        rst_n = 1'b0;
        repeat (2) step();
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_data", o_data, 32'd0);
        check("rst_tx_data", {24'd0, o_tx_data}, 32'd0);
        check("rst_valid", {31'd0, o_data_valid}, 32'd0);
        check("rst_tx_start", {31'd0, o_tx_start}, 32'd0);
        check("rst_done", {31'd0, o_done_tick}, 32'd0);
        rst_n = 1'b1;
        step();

        // Start and stop together in idle: stay idle
        i_start = 1'b1;
        i_stop = 1'b1;
        step();
        i_start = 1'b0;
        i_stop = 1'b0;
        check("start_stop_idle", {31'd0, o_busy}, 32'd0);
        step();
        check("start_stop_idle2", {31'd0, o_busy}, 32'd0);

        // All-fast capture and byte hand-off
        capture(32'hFFFF_FFFF, 32'hA5A5_3C0F, 1'b0, 1'b0, 0, 32'hA5A5_3C0F, 1025);
        serve(32'hA5A5_3C0F);

        // Mixed periods, with ignored start/done pulses during capture
        capture(32'h0000_FFFF, 32'h1234_5678, 1'b0, 1'b1, 0, 32'h1234_5678, 1537);
        serve(32'h1234_5678);

        // Abort mid-capture
        s_valid = n_valid;
        s_start = n_start;
        s_done = n_done;
        capture(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 500, 32'd0, 0);
        repeat (5) step();
        check("stop_data_kept", o_data, 32'h1234_5678);
        check("stop_no_valid", n_valid - s_valid, 0);
        check("stop_no_pulses", (n_start - s_start) + (n_done - s_done), 0);

        // Withheld acknowledge, ignored restart, then stop colliding with done
        capture(32'hFFFF_FFFF, 32'hA5A5_3C0F, 1'b0, 1'b0, 0, 32'hA5A5_3C0F, 1025);
        s_start = n_start;
        s_done = n_done;
        step();
        check("wait_tx_start", {31'd0, o_tx_start}, 32'd1);
        check("wait_tx_byte", {24'd0, o_tx_data}, 32'h0F);
        for (int i = 0; i < 1000; i++) begin
            i_start = (i == 100);
            step();
        end
        i_start = 1'b0;
        check("wait_tx_hold", {24'd0, o_tx_data}, 32'h0F);
        check("wait_one_start", n_start - s_start, 1);
        check("wait_busy", {31'd0, o_busy}, 32'd1);
        i_stop = 1'b1;
        i_tx_done_tick = 1'b1;
        step();
        i_stop = 1'b0;
        i_tx_done_tick = 1'b0;
        check("stop_wins_busy", {31'd0, o_busy}, 32'd0);
        repeat (5) step();
        check("stop_wins_no_start", n_start - s_start, 1);
        check("stop_wins_no_done", n_done - s_done, 0);
        check("stop_wins_data", o_data, 32'hA5A5_3C0F);

        // Reset during S_WAIT
        capture(32'hFFFF_0000, 32'hDEAD_BEEF, 1'b0, 1'b0, 0, 32'hDEAD_BEEF, 1537);
        step();
        check("pre_rst_byte", {24'd0, o_tx_data}, 32'hEF);
        repeat (3) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mid_rst_busy", {31'd0, o_busy}, 32'd0);
        check("mid_rst_data", o_data, 32'd0);
        check("mid_rst_tx_data", {24'd0, o_tx_data}, 32'd0);
        check("mid_rst_pulses", {29'd0, o_data_valid, o_tx_start, o_done_tick}, 32'd0);

        // Fresh capture after reset, glitch at each bit centre
`ifdef DIFF_FREQ_MAJORITY_VOTE_EN
        glitch_exp = 32'hC3C3_5A5A;
`else
        glitch_exp = 32'h3C3C_A5A5;
`endif
        capture(32'hF0F0_F0F0, 32'hC3C3_5A5A, 1'b1, 1'b0, 0, glitch_exp, 1537);
        serve(glitch_exp);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
